// File: rtl/cdc_fifo_arb_pkg.sv
// ============================================================================
// Module  : cdc_fifo_arb_pkg
// Brief   : Shared types, constants and width helper for the FIFO write arbiter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package cdc_fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int STAT_WIDTH = 8;

    // Minimum of one bit so single-value ranges still yield a usable vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
// Module  : rr_priority_picker
// Brief   : Combinational round-robin pick: first valid index above rr_last.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rr_priority_picker
    import cdc_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [clog2(NUM_REQ)-1:0] rr_last_i,
    output logic [clog2(NUM_REQ)-1:0] pick_id_o,
    output logic                      any_valid_o
);

    localparam int IDW = clog2(NUM_REQ);
    localparam logic [IDW:0] NUM_REQ_W = (IDW+1)'(NUM_REQ);

    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;
    logic           w_found;

    always_comb begin
        pick_id_o = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, rr_last_i} + (IDW+1)'(k);
            if (w_sum >= NUM_REQ_W) w_sum = w_sum - NUM_REQ_W;
            w_idx = w_sum[IDW-1:0];
            if (!w_found && req_valid_i[w_idx]) begin
                w_found   = 1'b1;
                pick_id_o = w_idx;
            end
        end
    end

    assign any_valid_o = |req_valid_i;

endmodule

`default_nettype wire

// File: rtl/cdc_fifo_write_arbiter.sv
// ============================================================================
// Module  : cdc_fifo_write_arbiter
// Brief   : Round-robin packet-locking arbiter for the CDC FIFO write port.
//           Optional per-requester beat counters: define FIFO_ARB_STATS_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cdc_fifo_write_arbiter
    import cdc_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    output logic                          fifo_write_increment,
    output logic [clog2(NUM_REQ)-1:0]     grant_id,
    output logic                          busy,
    output logic [NUM_REQ*8-1:0]          stat_beats
);

    localparam int IDW = clog2(NUM_REQ);
    localparam int BCW = clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  rr_last_q, rr_last_d;
    logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;

    logic [IDW-1:0]        w_pick;
    logic                  w_any_valid;
    logic                  w_g_valid;
    logic                  w_g_last;
    logic [DATA_WIDTH-1:0] w_g_data;
    logic                  w_accept;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_valid_i (req_valid),
        .rr_last_i   (rr_last_q),
        .pick_id_o   (w_pick),
        .any_valid_o (w_any_valid)
    );

    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
                w_g_valid = req_valid[i];
                w_g_last  = req_last[i];
                w_g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy                 = (state_q == ARB_LOCK);
    assign w_accept             = busy & w_g_valid & ~fifo_full;
    assign fifo_write_increment = w_accept;
    assign fifo_write_data      = busy ? w_g_data : '0;
    assign grant_id             = grant_q;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = busy & (grant_q == IDW'(i)) & ~fifo_full;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_any_valid) begin
                    grant_d    = w_pick;
                    beat_cnt_d = '0;
                    state_d    = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                if (w_accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    // Cap release is silent: the same requester must re-arbitrate.
                    if (w_g_last || (beat_cnt_q == BURST_LAST)) begin
                        state_d   = ARB_IDLE;
                        rr_last_d = grant_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_last_q  <= IDW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [STAT_WIDTH-1:0] stat_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stat_q <= '0;
                end else if (req_valid[gi] && req_ready[gi] && (stat_q != '1)) begin
                    stat_q <= stat_q + 1'b1;
                end
            end
            assign stat_beats[gi*STAT_WIDTH +: STAT_WIDTH] = stat_q;
        end
    endgenerate
`else
    assign stat_beats = '0;
`endif

endmodule

`default_nettype wire
